// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO slice.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH_DEF = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 8;

  // Accepted-operation decode used for the occupancy update.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer; DEPTH is a power of two so the natural binary
// rollover gives the DEPTH-1 -> 0 wrap with no gap.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  output logic [ptr_w(DEPTH)-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and
// one-cycle overflow/underflow pulses for rejected requests.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic                      rvalid,
  output logic                      full,
  output logic                      empty,
  output logic [ptr_w(DEPTH):0]     count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  fifo_op_e         op;

  // full/empty come from the registered count, so they lag the operation.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign op      = fifo_op_e'({push_ok, pop_ok});

  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push_ok),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop_ok),
    .ptr   (rd_ptr)
  );

  // Storage is deliberately not reset; contents are discarded via the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata     <= '0;
      rvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rvalid    <= pop_ok;
      overflow  <= push & full;
      underflow <= pop & empty;
      if (pop_ok) begin
        rdata <= mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case (op)
        OP_PUSH: count <= count + 1'b1;
        OP_POP:  count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_ovf_unless_full : assert property (@(posedge clk) disable iff (!rst_n)
    overflow |-> ($past(count) == FULL_CNT));
  a_no_udf_unless_empty : assert property (@(posedge clk) disable iff (!rst_n)
    underflow |-> ($past(count) == '0));
  a_full_empty_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(full && empty));
  a_ovf_udf_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(overflow && underflow));
  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count <= FULL_CNT);

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 8: number of storage entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1: single clock; all state updates on the posedge.
REQ-004 rst_n  input  1: asynchronous reset, active-low.
REQ-005 push  input  1: write request for wdata this cycle.
REQ-006 wdata  input  WIDTH: write data, sampled when a push is accepted.
REQ-007 pop  input  1: read request this cycle.
REQ-008 rdata  output  WIDTH: registered read data, valid while rvalid=1.
REQ-009 rvalid  output  1: one-cycle pulse, the cycle after an accepted pop.
REQ-010 full  output  1: high when count==DEPTH.
REQ-011 empty  output  1: high when count==0.
REQ-012 count  output  $clog2(DEPTH)+1: number of stored entries.
REQ-013 overflow  output  1: one-cycle pulse, the cycle after a push was rejected.
REQ-014 underflow  output  1: one-cycle pulse, the cycle after a pop was rejected.

Function
REQ-015 A push SHALL be accepted only when push=1 and full=0; the word is written at wr_ptr, and wr_ptr increments.
REQ-016 A pop SHALL be accepted only when pop=1 and empty=0; mem[rd_ptr] loads into rdata, rd_ptr increments, and rvalid=1 the next cycle.
REQ-017 Read latency SHALL be exactly 1 cycle from an accepted pop to rdata/rvalid.
REQ-018 rdata SHALL hold its last value when no pop is accepted.
REQ-019 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-020 count SHALL change as follows: +1 on push only, -1 on pop only, unchanged on both or neither; it SHALL never exceed DEPTH or go below 0.
REQ-021 full and empty SHALL be decoded from the registered count, so they change one cycle after the accepted operation.
REQ-022 Push and pop while full SHALL accept the pop and reject the push, raising overflow; count becomes DEPTH-1.
REQ-023 Push and pop while empty SHALL accept the push and reject the pop, raising underflow; count becomes 1 and rvalid stays 0.
REQ-024 Push and pop with 0<count<DEPTH SHALL accept both; count and full/empty are unchanged.
REQ-025 Data SHALL be returned in strict FIFO order, including across pointer wrap.
REQ-026 overflow and underflow SHALL be independent and may pulse in the same cycle only if full and empty are both true, which is impossible; an implementation SHALL assert this never occurs.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately clear wr_ptr, rd_ptr, count, rdata, rvalid, overflow and underflow, giving empty=1 and full=0.
REQ-028 Memory contents SHALL NOT be reset; stored data is discarded logically.
REQ-029 A reset asserted mid-operation SHALL abort it; the first accepted push after release lands at index 0.

Structure
REQ-030 Package fifo_pkg SHALL hold the default WIDTH and DEPTH constants and the function ptr_w(depth)=$clog2(depth).
REQ-031 Sub-module fifo_ptr (parameter DEPTH; inputs clk, rst_n, inc; output ptr) SHALL implement the wrapping pointer and be instantiated twice.
REQ-032 The RTL SHALL contain concurrent assertions: no overflow while count<DEPTH, no underflow while count>0, and full and empty never high together.

Verification
REQ-033 Reset, then 8 pushes of 0x10..0x17 with no pop -> full=1 and count=8; a 9th push of 0xFF -> overflow pulse, count stays 8.
REQ-034 Then 8 pops -> rdata 0x10..0x17 in order, each with an rvalid pulse; then empty=1; a 9th pop -> underflow pulse and no rvalid.
REQ-035 When empty, push and pop together with wdata=0xA5 -> underflow pulse, count=1; the next pop returns 0xA5.
REQ-036 When full, push and pop together -> the oldest word is read, overflow pulses, count=7.
REQ-037 20 random push/pop cycles spanning at least 2 pointer wraps -> scoreboard order matches and count tracks the reference model every cycle.
REQ-038 With count=5, pulse rst_n low asynchronously between clock edges -> empty=1, count=0 and rvalid=0 immediately; the first data pushed after release is returned first.
